cache_miss_arbiter: RTL and testbench
=====================================

# cache_miss_arbiter

Sequences all main-memory traffic for the three-stage CPU. It shares one memory command/data port between instruction-cache line fills and data-cache fills and write-throughs. It owns one transaction at a time and drives the pipeline `Stall` line while any cache request is outstanding. It sits between the I/D caches and the memory controller, alongside the datapath.

## Interface
Parameters:
- `LINE_BEATS`, 4: 32-bit beats per cache-line fill; power of two, 2–16.
- `ADDR_W`, 32: byte address width.

Ports:
- Clocking and reset:
  - `CLK` in 1: single clock; all state updates on its rising edge.
  - `reset` in 1: synchronous and active-high.
- Instruction-cache requester:
  - `ic_req` in 1: I-cache fill request, level; held until `ic_done`.
  - `ic_addr` in `ADDR_W`: miss address.
  - `ic_rdata` out 32: fill beat data.
  - `ic_rvalid` out 1: beat valid.
  - `ic_done` out 1: one-cycle completion pulse.
- Data-cache requester:
  - `dc_req` in 1: D-cache request, level; held until `dc_done`.
  - `dc_we` in 1: 1 = single-word write, 0 = line fill.
  - `dc_addr` in `ADDR_W`: request address.
  - `dc_wdata` in 32: write data.
  - `dc_wmask` in 4: byte enables, bit 3 = bits [31:24].
  - `dc_rdata`, `dc_rvalid`, `dc_done` out 32/1/1: same meaning as the I-cache outputs.
- Memory command port:
  - `mem_cmd_valid` out 1: command valid.
  - `mem_cmd_ready` in 1: command accepted when valid & ready.
  - `mem_cmd_we`, `mem_cmd_addr`, `mem_wdata`, `mem_wmask` out 1/`ADDR_W`/32/4: command fields.
- Memory read-data port:
  - `mem_rdata` in 32: read beat data.
  - `mem_rvalid` in 1: read beat valid.
- Pipeline and status:
  - `Stall` out 1: freeze pipeline.
  - `busy` out 1: FSM not IDLE.

## Operation
- FSM states: IDLE, CMD, RDATA, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner and latch its owner, address, we, wdata and wmask, then go to CMD.
  - Default arbitration is fixed priority: D-cache beats I-cache.
- **CMD**
  - Hold `mem_cmd_valid`=1 with the latched fields stable until `mem_cmd_ready`.
  - Fill address is line-aligned: low log2(`LINE_BEATS`)+2 bits cleared.
  - Write address is word-aligned: low 2 bits cleared.
  - I-cache commands force `mem_cmd_we`=0 and `mem_wmask`=0.
  - On acceptance: a write goes to DONE; a fill goes to RDATA with the beat counter cleared.
- **RDATA**
  - Each `mem_rvalid` is forwarded combinationally to the owner only: `x_rdata`=`mem_rdata`, `x_rvalid`=1. The counter then increments.
  - The beat with count `LINE_BEATS`-1 moves the FSM to DONE.
  - Beats arrive in ascending address order; `mem_rvalid` gaps are allowed.
- **DONE**
  - Assert the owner's `x_done` for exactly one cycle, then return to IDLE.
  - The requester drops `x_req` on the same edge, so IDLE never re-grants a completed request.
- `Stall` = (`ic_req` & ~`ic_done`) | (`dc_req` & ~`dc_done`), combinational.
- A losing requester keeps stalling and is granted in the IDLE cycle after the winner's DONE.
- `mem_rvalid` outside RDATA is ignored: no forwarding, no counter change.

## Timing
- Reset values:
  - FSM = IDLE; beat counter = 0; last-grant = I-cache.
  - Every registered output is 0.
  - Combinational outputs are 0 while IDLE with no request (`Stall` follows its request terms).
- `reset` asserted mid-transaction aborts it:
  - Next cycle: IDLE, `mem_cmd_valid`=0, no `x_done` pulse.
  - Late `mem_rvalid` beats are dropped.
- Latency with request at cycle 0 in IDLE:
  - `mem_cmd_valid` in cycle 1.
  - Write with ready in cycle 1: `dc_done` in cycle 2.
  - Fill with ready in cycle 1 and back-to-back beats in cycles 2..1+`LINE_BEATS`: `x_done` in cycle 2+`LINE_BEATS`.
- Back-to-back transactions have at least one IDLE cycle between DONE and the next CMD.
- A simultaneous `ic_req` and `dc_req` rise is resolved in one IDLE cycle; the loser waits with no lost request.
- The beat counter is log2(`LINE_BEATS`) bits and does not wrap past `LINE_BEATS`-1.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both requests are pending in IDLE, grant the requester that did not win the last grant.
  - Last-grant updates on every grant and resets to I-cache, so the first contention still goes to the D-cache.
  - A lone request is granted immediately.
- `ARB_ROUND_ROBIN_EN` undefined: fixed D-cache priority; last-grant is not implemented.

## Test plan
- I-cache fill: `ic_addr`=0x1000_0014, `LINE_BEATS`=4, ready immediately, beats 0xA0..0xA3 back-to-back → `mem_cmd_addr`=0x1000_0010, four `ic_rvalid` pulses in order, `ic_done` one cycle after the last beat, `Stall` low in the cycle after `ic_done`.
- D-cache write: `dc_we`=1, addr 0x0000_0106, wdata 0xDEADBEEF, wmask 4'b0011, `mem_cmd_ready` held low 3 cycles → command stable all 3 cycles, `mem_cmd_addr`=0x0000_0104, `dc_done` the cycle after acceptance, no `dc_rvalid`.
- Contention: `ic_req` and `dc_req` rise in the same cycle → D-cache served first, then I-cache; `Stall` high throughout. With `ARB_ROUND_ROBIN_EN`, a second simultaneous pair is served I-cache first.
- Gapped fill: D-cache fill with `mem_rvalid` on cycles 3, 5, 6, 9 → `dc_done` in cycle 10, no `ic_rvalid` ever.
- Reset during RDATA after 2 beats, then 2 stray `mem_rvalid` → all outputs 0, no `x_done`, strays ignored; the next fill completes normally with counter restarted at 0.

Source files
------------

// File: rtl/cache_miss_arbiter.sv
// cache_miss_arbiter
// Arbitrates the single main-memory command/data port between I-cache line
// fills and D-cache fills / single-word write-throughs. It owns one
// transaction at a time and freezes the pipeline while any cache request is
// outstanding.
//
// Build option: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D-cache wins over I-cache.
//   defined   : on contention, grant the requester that lost the last grant.
//
// Ports
//   CLK, reset                 clock, synchronous active-high reset
//   ic_req/ic_addr             I-cache fill request (level) and miss address
//   ic_rdata/ic_rvalid/ic_done I-cache fill beats and completion pulse
//   dc_req/dc_we/dc_addr       D-cache request (we=1 write, 0 line fill)
//   dc_wdata/dc_wmask          D-cache write data and byte enables
//   dc_rdata/dc_rvalid/dc_done D-cache fill beats and completion pulse
//   mem_cmd_*                  memory command (valid/ready handshake)
//   mem_wdata/mem_wmask        memory write data and byte enables
//   mem_rdata/mem_rvalid       memory read beats
//   Stall                      pipeline freeze
//   busy                       a transaction is in flight
//
// State  | meaning
// IDLE   | no transaction owned; arbitrate pending requests
// CMD    | command presented, waiting for mem_cmd_ready
// RDATA  | collecting LINE_BEATS read beats for the owner
// DONE   | one-cycle completion pulse to the owner
module cache_miss_arbiter #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [31:0]       ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    input  logic [3:0]        dc_wmask,
    output logic [31:0]       dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              Stall,
    output logic              busy
);

    localparam int CW = $clog2(LINE_BEATS);
    localparam int LB = CW + 2;
    localparam logic [CW-1:0]     LAST_BEAT = CW'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((1 << LB) - 1));
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_RDATA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner_dc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [CW-1:0]     r_cnt;

    logic              w_take;
    logic              w_grant_dc;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [ADDR_W-1:0] w_sel_addr_al;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dc;

    // Alternate only under contention; a lone requester always wins.
    always_comb begin
        if (dc_req && ic_req) begin
            w_grant_dc = ~r_last_dc;
        end else begin
            w_grant_dc = dc_req;
        end
    end
`else
    assign w_grant_dc = dc_req;
`endif

    assign w_take        = (r_state == S_IDLE) && (ic_req || dc_req);
    assign w_sel_we      = w_grant_dc & dc_we;
    assign w_sel_addr    = w_grant_dc ? dc_addr : ic_addr;
    // Alignment is applied once at grant so CMD presents a stable address.
    assign w_sel_addr_al = w_sel_we ? (w_sel_addr & WORD_MASK) : (w_sel_addr & LINE_MASK);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner_dc <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_dc  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_owner_dc <= w_grant_dc;
                r_addr     <= w_sel_addr_al;
                r_we       <= w_sel_we;
                r_wdata    <= w_grant_dc ? dc_wdata : 32'h0;
                r_wmask    <= w_grant_dc ? dc_wmask : 4'h0;
`ifdef ARB_ROUND_ROBIN_EN
                r_last_dc  <= w_grant_dc;
`endif
            end
            if (r_state == S_CMD && mem_cmd_ready) begin
                r_cnt <= '0;
            end else if (r_state == S_RDATA && mem_rvalid && r_cnt != LAST_BEAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        ic_rdata      = '0;
        ic_rvalid     = 1'b0;
        ic_done       = 1'b0;
        dc_rdata      = '0;
        dc_rvalid     = 1'b0;
        dc_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = r_we;
                mem_cmd_addr  = r_addr;
                mem_wdata     = r_wdata;
                mem_wmask     = r_wmask;
                if (mem_cmd_ready) begin
                    w_state_nxt = r_we ? S_DONE : S_RDATA;
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    if (r_owner_dc) begin
                        dc_rvalid = 1'b1;
                        dc_rdata  = mem_rdata;
                    end else begin
                        ic_rvalid = 1'b1;
                        ic_rdata  = mem_rdata;
                    end
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ic_done     = ~r_owner_dc;
                dc_done     = r_owner_dc;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        Stall = (ic_req & ~ic_done) | (dc_req & ~dc_done);
        busy  = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
module tb_cache_miss_arbiter;

    localparam int LB = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic [31:0]   ic_rdata;
    logic          ic_rvalid;
    logic          ic_done;
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [31:0]   dc_wdata;
    logic [3:0]    dc_wmask;
    logic [31:0]   dc_rdata;
    logic          dc_rvalid;
    logic          dc_done;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          Stall;
    logic          busy;

    always #5 clk = ~clk;

    cache_miss_arbiter #(.LINE_BEATS(LB), .ADDR_W(AW)) dut (
        .CLK(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wmask(dc_wmask), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
        .dc_done(dc_done),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .Stall(Stall), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: one owned transfer with a pending-command
    // flag and a count of beats still owed; a finished transfer spends one
    // cycle announcing completion.
    bit            m_init = 0;
    bit            m_own  = 0;
    bit            m_cmd  = 0;
    bit            m_fin  = 0;
    bit            m_dc   = 0;
    bit            m_we   = 0;
    bit            m_last_dc = 0;
    int            m_left = 0;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wmask;

    // Observations for the directed literal checks.
    logic [31:0]   ic_beats[$];
    logic [31:0]   dc_beats[$];
    int            ic_done_cyc;
    int            dc_done_cyc;
    int            acc_cyc;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [3:0]    acc_wmask;
    logic [31:0]   acc_wdata;
    bit            stall_log[4096];
    bit            drop_ic = 0;
    bit            drop_dc = 0;

    initial forever begin
        bit e_cmd, e_beat, e_icd, e_dcd, e_stall, e_busy;
        logic [AW-1:0] a;
        @(negedge clk);
        if (m_init) begin
            e_cmd   = m_own && m_cmd;
            e_beat  = m_own && !m_cmd && !m_we && mem_rvalid;
            e_icd   = m_fin && !m_dc;
            e_dcd   = m_fin && m_dc;
            e_stall = (ic_req && !e_icd) || (dc_req && !e_dcd);
            e_busy  = m_own || m_fin;
            check("cmd_valid", mem_cmd_valid, e_cmd);
            check("ic_rvalid", ic_rvalid, e_beat && !m_dc);
            check("dc_rvalid", dc_rvalid, e_beat && m_dc);
            check("ic_done", ic_done, e_icd);
            check("dc_done", dc_done, e_dcd);
            check("stall", Stall, e_stall);
            check("busy", busy, e_busy);
            if (e_cmd) begin
                check("cmd_addr", mem_cmd_addr, m_addr);
                check("cmd_we", mem_cmd_we, m_we);
                check("cmd_wmask", mem_wmask, m_wmask);
                if (m_we) check("cmd_wdata", mem_wdata, m_wdata);
            end
            if (e_beat && !m_dc) check("ic_rdata", ic_rdata, mem_rdata);
            if (e_beat && m_dc) check("dc_rdata", dc_rdata, mem_rdata);
            if (!e_busy && !ic_req && !dc_req) begin
                check("idle_cmd_zero", |{mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wmask}, 1'b0);
                check("idle_rdata_zero", |{ic_rdata, dc_rdata}, 1'b0);
            end
        end

        if (ic_rvalid) ic_beats.push_back(ic_rdata);
        if (dc_rvalid) dc_beats.push_back(dc_rdata);
        if (ic_done) begin ic_done_cyc = cyc; drop_ic = 1; end
        if (dc_done) begin dc_done_cyc = cyc; drop_dc = 1; end
        if (mem_cmd_valid && mem_cmd_ready) begin
            acc_cyc = cyc; acc_addr = mem_cmd_addr; acc_we = mem_cmd_we;
            acc_wmask = mem_wmask; acc_wdata = mem_wdata;
        end
        if (cyc < 4096) stall_log[cyc] = Stall;

        // Advance the reference across the coming rising edge.
        if (reset) begin
            m_init = 1; m_own = 0; m_cmd = 0; m_fin = 0; m_left = 0; m_last_dc = 0;
        end else if (m_init) begin
            if (m_fin) begin
                m_fin = 0;
            end else if (m_own) begin
                if (m_cmd) begin
                    if (mem_cmd_ready) begin
                        m_cmd = 0;
                        if (m_we) begin m_own = 0; m_fin = 1; end
                        else m_left = LB;
                    end
                end else if (mem_rvalid) begin
                    m_left--;
                    if (m_left == 0) begin m_own = 0; m_fin = 1; end
                end
            end else if (ic_req || dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                m_dc = (ic_req && dc_req) ? !m_last_dc : dc_req;
                m_last_dc = m_dc;
`else
                m_dc = dc_req;
`endif
                m_own = 1; m_cmd = 1;
                m_we  = m_dc && dc_we;
                a     = m_dc ? dc_addr : ic_addr;
                m_addr  = m_we ? (a & ~32'h3) : (a & ~32'(LB * 4 - 1));
                m_wdata = dc_wdata;
                m_wmask = m_dc ? dc_wmask : 4'h0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (drop_ic) begin ic_req = 0; drop_ic = 0; end
        if (drop_dc) begin dc_req = 0; drop_dc = 0; end
    endtask

    // Cycle k of the run (k=0 is the cycle the request is raised) gets
    // ready=rdy[k], rvalid=rv[k]; beat data counts up from base.
    task automatic run(input int n, input logic [31:0] rdy, input logic [31:0] rv, input logic [31:0] base);
        int nb = 0;
        for (int k = 0; k < n; k++) begin
            mem_cmd_ready = rdy[k];
            mem_rvalid    = rv[k];
            mem_rdata     = rv[k] ? base + 32'(nb) : 32'h0;
            if (rv[k]) nb++;
            step();
        end
        mem_cmd_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic clear_logs();
        ic_beats.delete(); dc_beats.delete();
        ic_done_cyc = -1; dc_done_cyc = -1; acc_cyc = -1;
    endtask

    initial begin
        int t0;
        reset = 1; ic_req = 0; ic_addr = 0; dc_req = 0; dc_we = 0; dc_addr = 0;
        dc_wdata = 0; dc_wmask = 0; mem_cmd_ready = 0; mem_rdata = 0; mem_rvalid = 0;
        clear_logs();
        step(); step();
        reset = 0;
        step();
        check("rst_busy", busy, 0);
        check("rst_cmd_valid", mem_cmd_valid, 0);
        check("rst_stall", Stall, 0);
        check("rst_done", {ic_done, dc_done}, 0);

        // I-cache line fill, immediate ready, back-to-back beats.
        clear_logs(); t0 = cyc;
        ic_req = 1; ic_addr = 32'h1000_0014;
        run(8, 32'b10, 32'b111100, 32'hA0);
        check("t1_addr", acc_addr, 32'h1000_0010);
        check("t1_acc_cyc", acc_cyc - t0, 1);
        check("t1_we", acc_we, 0);
        check("t1_nbeats", ic_beats.size(), 4);
        for (int i = 0; i < ic_beats.size(); i++) check("t1_beat", ic_beats[i], 32'hA0 + 32'(i));
        check("t1_done_cyc", ic_done_cyc - t0, 6);
        check("t1_stall_after", stall_log[t0 + 7], 0);
        check("t1_no_dc", dc_beats.size(), 0);

        // D-cache write, ready held off, stray rvalid while in CMD.
        clear_logs(); t0 = cyc;
        dc_req = 1; dc_we = 1; dc_addr = 32'h0000_0106; dc_wdata = 32'hDEAD_BEEF; dc_wmask = 4'b0011;
        run(7, 32'b10000, 32'b100, 32'h55);
        dc_we = 0;
        check("t2_addr", acc_addr, 32'h0000_0104);
        check("t2_acc_cyc", acc_cyc - t0, 4);
        check("t2_wdata", acc_wdata, 32'hDEAD_BEEF);
        check("t2_wmask", acc_wmask, 4'b0011);
        check("t2_we", acc_we, 1);
        check("t2_done_cyc", dc_done_cyc - t0, 5);
        check("t2_no_rvalid", dc_beats.size() + ic_beats.size(), 0);

        // Contention pair 1: D-cache first in both builds.
        clear_logs(); t0 = cyc;
        ic_req = 1; ic_addr = 32'h3000_0008;
        dc_req = 1; dc_we = 1; dc_addr = 32'h40; dc_wdata = 32'h1234_5678; dc_wmask = 4'hF;
        run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h70);
        dc_we = 0;
        check("t3_dc_done", dc_done_cyc - t0, 2);
        check("t3_ic_done", ic_done_cyc - t0, 9);
        for (int i = 0; i < 9; i++) check("t3_stall_hi", stall_log[t0 + i], 1);
        check("t3_stall_lo", stall_log[t0 + 9], 0);

        // Lone D-cache write, so round-robin last-grant becomes D-cache.
        clear_logs(); t0 = cyc;
        dc_req = 1; dc_we = 1; dc_addr = 32'h80; dc_wdata = 32'h0BAD_F00D; dc_wmask = 4'h1;
        run(4, 32'hFFFF_FFFF, 32'h0, 32'h0);
        dc_we = 0;
        check("t3b_done", dc_done_cyc - t0, 2);

        // Contention pair 2.
        clear_logs(); t0 = cyc;
        ic_req = 1; ic_addr = 32'h3000_0020;
        dc_req = 1; dc_we = 1; dc_addr = 32'h44; dc_wdata = 32'hCAFE_0001; dc_wmask = 4'hC;
        run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h90);
        dc_we = 0;
`ifdef ARB_ROUND_ROBIN_EN
        check("t3c_ic_done", ic_done_cyc - t0, 6);
        check("t3c_dc_done", dc_done_cyc - t0, 9);
`else
        check("t3c_dc_done", dc_done_cyc - t0, 2);
        check("t3c_ic_done", ic_done_cyc - t0, 9);
`endif

        // Gapped D-cache fill.
        clear_logs(); t0 = cyc;
        dc_req = 1; dc_we = 0; dc_addr = 32'h0000_2468; dc_wmask = 4'h0;
        run(12, 32'b10, 32'b10_0110_1000, 32'hB0);
        check("t4_addr", acc_addr, 32'h0000_2460);
        check("t4_done_cyc", dc_done_cyc - t0, 10);
        check("t4_nbeats", dc_beats.size(), 4);
        for (int i = 0; i < dc_beats.size(); i++) check("t4_beat", dc_beats[i], 32'hB0 + 32'(i));
        check("t4_no_ic", ic_beats.size(), 0);

        // Reset in RDATA after two beats, then stray beats.
        clear_logs(); t0 = cyc;
        ic_req = 1; ic_addr = 32'h0000_0200;
        run(4, 32'b10, 32'b1100, 32'hD0);
        reset = 1;
        step();
        reset = 0; ic_req = 0;
        check("t5_busy", busy, 0);
        check("t5_cmd_valid", mem_cmd_valid, 0);
        mem_rvalid = 1; mem_rdata = 32'hEE;
        step();
        check("t5_stray_rv", {ic_rvalid, dc_rvalid}, 0);
        step();
        mem_rvalid = 0; mem_rdata = 0;
        step();
        check("t5_nbeats", ic_beats.size(), 2);
        check("t5_no_done", ic_done_cyc, -1);

        // Fill after the abort must take a full line of beats.
        clear_logs(); t0 = cyc;
        ic_req = 1; ic_addr = 32'h0000_0044;
        run(8, 32'b10, 32'b111100, 32'hC0);
        check("t6_addr", acc_addr, 32'h0000_0040);
        check("t6_done_cyc", ic_done_cyc - t0, 6);
        check("t6_nbeats", ic_beats.size(), 4);
        for (int i = 0; i < ic_beats.size(); i++) check("t6_beat", ic_beats[i], 32'hC0 + 32'(i));

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
